// File: rtl/counter_ext_if.sv
// Bus bundle for counter_ext: control inputs, load data, count and status outputs.
// Clear_i is present only when COUNTER_EXT_SYNC_CLEAR_EN is defined.
interface counter_ext_if #(
    parameter int unsigned Width = 32
);
    logic             Enable_i;
    logic             Up_i;
    logic             Load_i;
    logic [Width-1:0] LoadData_i;
    logic [Width-1:0] Data_o;
    logic             AtMax_o;
    logic             AtMin_o;
    logic             Wrap_o;
`ifdef COUNTER_EXT_SYNC_CLEAR_EN
    logic             Clear_i;

    modport master (
        output Enable_i, Up_i, Load_i, LoadData_i, Clear_i,
        input  Data_o, AtMax_o, AtMin_o, Wrap_o
    );
    modport slave (
        input  Enable_i, Up_i, Load_i, LoadData_i, Clear_i,
        output Data_o, AtMax_o, AtMin_o, Wrap_o
    );
`else
    modport master (
        output Enable_i, Up_i, Load_i, LoadData_i,
        input  Data_o, AtMax_o, AtMin_o, Wrap_o
    );
    modport slave (
        input  Enable_i, Up_i, Load_i, LoadData_i,
        output Data_o, AtMax_o, AtMin_o, Wrap_o
    );
`endif
endinterface

// File: rtl/counter_ext.sv
// Parametrised bounded up/down counter with load, saturate/wrap mode and boundary flags.
// Optional synchronous clear (top priority) enabled by COUNTER_EXT_SYNC_CLEAR_EN.
module counter_ext #(
    parameter int unsigned     Width = 32,
    parameter longint unsigned Init  = 8,
    parameter longint unsigned Min   = 8,
    parameter longint unsigned Max   = 64,
    parameter bit              Wrap  = 1'b0
) (
    input  logic        Clk_i,
    input  logic        Reset_n_i,
    counter_ext_if.slave bus
);

    // Reject inconsistent bound sets at elaboration time.
    generate
        if (Width < 2) begin : g_bad_width
            $error("counter_ext: Width must be >= 2");
        end
        if (Min > Init || Init > Max) begin : g_bad_init
            $error("counter_ext: require Min <= Init <= Max");
        end
        if (Width < 64 && Max > ((64'd1 << Width) - 64'd1)) begin : g_bad_max
            $error("counter_ext: Max does not fit in Width bits");
        end
    endgenerate

    localparam logic [Width-1:0] INIT_V = Width'(Init);
    localparam logic [Width-1:0] MIN_V  = Width'(Min);
    localparam logic [Width-1:0] MAX_V  = Width'(Max);
    localparam logic [Width-1:0] ONE_V  = Width'(1);

    logic [Width-1:0] count_q;
    logic             wrap_q;
    logic [Width-1:0] load_clamped;

    always_comb begin
        if (bus.LoadData_i < MIN_V) begin
            load_clamped = MIN_V;
        end else if (bus.LoadData_i > MAX_V) begin
            load_clamped = MAX_V;
        end else begin
            load_clamped = bus.LoadData_i;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk_i or negedge Reset_n_i) begin
        if (!Reset_n_i) begin
            count_q <= INIT_V;
            wrap_q  <= 1'b0;
        end else begin
            // NOTE: default the pulse low first so every branch below only sets it when wrapping.
            wrap_q <= 1'b0;
`ifdef COUNTER_EXT_SYNC_CLEAR_EN
            if (bus.Clear_i) begin
                count_q <= INIT_V;
            end else
`endif
            if (bus.Load_i) begin
                count_q <= load_clamped;
            end else if (bus.Enable_i) begin
                // Bound compared before stepping, so the Width-bit add/sub never overflows.
                if (bus.Up_i) begin
                    if (count_q < MAX_V) begin
                        count_q <= count_q + ONE_V;
                    end else if (Wrap) begin
                        count_q <= MIN_V;
                        wrap_q  <= 1'b1;
                    end
                end else begin
                    if (count_q > MIN_V) begin
                        count_q <= count_q - ONE_V;
                    end else if (Wrap) begin
                        count_q <= MAX_V;
                        wrap_q  <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.Data_o  = count_q;
    assign bus.AtMax_o = (count_q == MAX_V);
    assign bus.AtMin_o = (count_q == MIN_V);
    assign bus.Wrap_o  = wrap_q;

endmodule

// File: tb/tb_counter_ext.sv
// Directed bench for counter_ext: saturating default, wrapping and 4-bit full-range instances.
module tb_counter_ext;

    logic Clk_i;
    logic Reset_n_i;

    int checks = 0;
    int errors = 0;

    counter_ext_if #(.Width(32)) if_def  ();
    counter_ext_if #(.Width(32)) if_wrap ();
    counter_ext_if #(.Width(4))  if_small();

    counter_ext #(.Width(32), .Init(8), .Min(8), .Max(64), .Wrap(1'b0)) u_def (
        .Clk_i(Clk_i), .Reset_n_i(Reset_n_i), .bus(if_def.slave)
    );
    counter_ext #(.Width(32), .Init(8), .Min(8), .Max(64), .Wrap(1'b1)) u_wrap (
        .Clk_i(Clk_i), .Reset_n_i(Reset_n_i), .bus(if_wrap.slave)
    );
    counter_ext #(.Width(4), .Init(0), .Min(0), .Max(15), .Wrap(1'b1)) u_small (
        .Clk_i(Clk_i), .Reset_n_i(Reset_n_i), .bus(if_small.slave)
    );

    initial Clk_i = 1'b0;
    always #5 Clk_i = ~Clk_i;

    task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one edge and land 1 ns after it, away from the active edge.
    task automatic step();
        @(posedge Clk_i);
        #1;
    endtask

    task automatic check_def(input string tag, input longint unsigned d, input bit mx,
                             input bit mn, input bit w);
        check({tag, "_data"}, if_def.Data_o, d);
        check({tag, "_atmax"}, if_def.AtMax_o, mx);
        check({tag, "_atmin"}, if_def.AtMin_o, mn);
        check({tag, "_wrap"}, if_def.Wrap_o, w);
    endtask

    task automatic check_wrap(input string tag, input longint unsigned d, input bit mx,
                              input bit mn, input bit w);
        check({tag, "_data"}, if_wrap.Data_o, d);
        check({tag, "_atmax"}, if_wrap.AtMax_o, mx);
        check({tag, "_atmin"}, if_wrap.AtMin_o, mn);
        check({tag, "_wrap"}, if_wrap.Wrap_o, w);
    endtask

    task automatic check_small(input string tag, input longint unsigned d, input bit mx,
                               input bit mn, input bit w);
        check({tag, "_data"}, if_small.Data_o, d);
        check({tag, "_atmax"}, if_small.AtMax_o, mx);
        check({tag, "_atmin"}, if_small.AtMin_o, mn);
        check({tag, "_wrap"}, if_small.Wrap_o, w);
    endtask

    initial begin
        longint unsigned exp_d;

        Reset_n_i = 1'b0;
        if_def.Enable_i = 1'b0;   if_def.Up_i = 1'b0;   if_def.Load_i = 1'b0;   if_def.LoadData_i = '0;
        if_wrap.Enable_i = 1'b0;  if_wrap.Up_i = 1'b0;  if_wrap.Load_i = 1'b0;  if_wrap.LoadData_i = '0;
        if_small.Enable_i = 1'b0; if_small.Up_i = 1'b0; if_small.Load_i = 1'b0; if_small.LoadData_i = '0;
`ifdef COUNTER_EXT_SYNC_CLEAR_EN
        if_def.Clear_i = 1'b0; if_wrap.Clear_i = 1'b0; if_small.Clear_i = 1'b0;
`endif

        // Reset values
        step();
        step();
        check_def("rst_def", 8, 1'b0, 1'b1, 1'b0);
        check_wrap("rst_wrap", 8, 1'b0, 1'b1, 1'b0);
        check_small("rst_small", 0, 1'b0, 1'b1, 1'b0);
        Reset_n_i = 1'b1;

        // Saturating up-count: 8..64 then hold
        if_def.Enable_i = 1'b1;
        if_def.Up_i     = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            step();
            exp_d = (8 + i > 64) ? 64 : 8 + i;
            check("up_sat_data", if_def.Data_o, exp_d);
            check("up_sat_wrap", if_def.Wrap_o, 0);
        end
        check_def("up_sat_end", 64, 1'b1, 1'b0, 1'b0);
        check_wrap("hold_wrap", 8, 1'b0, 1'b1, 1'b0);

        // Wrap instance: up across Max, then down across Min
        if_wrap.Load_i = 1'b1; if_wrap.LoadData_i = 63;
        step();
        check_wrap("wl63", 63, 1'b0, 1'b0, 1'b0);
        if_wrap.Load_i = 1'b0; if_wrap.Enable_i = 1'b1; if_wrap.Up_i = 1'b1;
        step(); check_wrap("wu64", 64, 1'b1, 1'b0, 1'b0);
        step(); check_wrap("wu8",  8,  1'b0, 1'b1, 1'b1);
        step(); check_wrap("wu9",  9,  1'b0, 1'b0, 1'b0);
        if_wrap.Up_i = 1'b0;
        step(); check_wrap("wd8",  8,  1'b0, 1'b1, 1'b0);
        step(); check_wrap("wd64", 64, 1'b1, 1'b0, 1'b1);
        step(); check_wrap("wd63", 63, 1'b0, 1'b0, 1'b0);
        if_wrap.Enable_i = 1'b0;
        step(); check_wrap("whold", 63, 1'b0, 1'b0, 1'b0);

        // Loads with clamping; load beats simultaneous enable
        if_def.Load_i = 1'b1; if_def.LoadData_i = 3;
        step(); check_def("ld3", 8, 1'b0, 1'b1, 1'b0);
        if_def.LoadData_i = 100;
        step(); check_def("ld100", 64, 1'b1, 1'b0, 1'b0);
        if_def.LoadData_i = 20;
        step(); check_def("ld20", 20, 1'b0, 1'b0, 1'b0);
        if_def.Load_i = 1'b0;
        step(); check_def("up21", 21, 1'b0, 1'b0, 1'b0);
        if_def.Up_i = 1'b0;
        step(); check_def("dn20", 20, 1'b0, 1'b0, 1'b0);

        // Saturating down at Min
        if_def.Load_i = 1'b1; if_def.LoadData_i = 9;
        step(); check_def("ld9", 9, 1'b0, 1'b0, 1'b0);
        if_def.Load_i = 1'b0;
        step(); check_def("dn8", 8, 1'b0, 1'b1, 1'b0);
        step(); check_def("dn_sat", 8, 1'b0, 1'b1, 1'b0);

        // Asynchronous reset mid-count, with a wrap pulse in flight
        if_def.Load_i = 1'b1;  if_def.LoadData_i = 36;
        if_wrap.Load_i = 1'b1; if_wrap.LoadData_i = 64;
        step();
        if_def.Load_i = 1'b0;  if_def.Up_i = 1'b1;
        if_wrap.Load_i = 1'b0; if_wrap.Enable_i = 1'b1; if_wrap.Up_i = 1'b1;
        step();
        check_def("pre_rst", 37, 1'b0, 1'b0, 1'b0);
        check_wrap("pre_rst_w", 8, 1'b0, 1'b1, 1'b1);
        #3;
        Reset_n_i = 1'b0;
        #1;
        check_def("async_rst", 8, 1'b0, 1'b1, 1'b0);
        check_wrap("async_rst_w", 8, 1'b0, 1'b1, 1'b0);
        if_def.Enable_i = 1'b0;
        if_wrap.Enable_i = 1'b0;
        step();
        Reset_n_i = 1'b1;
        step();
        check_def("post_rst", 8, 1'b0, 1'b1, 1'b0);

        // 4-bit full range: 0 down wraps to 15, 15 up wraps to 0
        if_small.Enable_i = 1'b1; if_small.Up_i = 1'b0;
        step(); check_small("s_dn15", 15, 1'b1, 1'b0, 1'b1);
        step(); check_small("s_dn14", 14, 1'b0, 1'b0, 1'b0);
        if_small.Up_i = 1'b1;
        step(); check_small("s_up15", 15, 1'b1, 1'b0, 1'b0);
        step(); check_small("s_up0",  0,  1'b0, 1'b1, 1'b1);
        step(); check_small("s_up1",  1,  1'b0, 1'b0, 1'b0);
        if_small.Enable_i = 1'b0;

`ifdef COUNTER_EXT_SYNC_CLEAR_EN
        // Clear overrides a simultaneous load and enable
        if_def.Load_i = 1'b1; if_def.LoadData_i = 50;
        step(); check_def("ld50", 50, 1'b0, 1'b0, 1'b0);
        if_def.Clear_i = 1'b1; if_def.LoadData_i = 30; if_def.Enable_i = 1'b1;
        step(); check_def("clear", 8, 1'b0, 1'b1, 1'b0);
        if_def.Clear_i = 1'b0; if_def.Load_i = 1'b0; if_def.Enable_i = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/counter_ext.md
Name: counter_ext

Overview:
Parametrised up/down counter, the next generation of the fixed-init counter.
- Generalised in width, init value and count bounds.
- Adds direction control, count enable, parallel load, and a selectable saturate or wrap mode.
- Provides registered boundary flags and a wrap pulse.
- Used as a building block for timers and sequencers, and as a formal-verification target with bounded-range properties.

Parameters:
- Width, 32, counter width in bits; must be >= 2.
- Init, 8, value taken on reset; must satisfy Min <= Init <= Max.
- Min, 8, lower count bound, inclusive.
- Max, 64, upper count bound, inclusive; must satisfy Max <= 2**Width-1.
- Wrap, 0, boundary mode: 0 = saturate at bounds, 1 = wrap to the opposite bound.

Ports:
- Clk_i  input  1  single clock; all state changes on its rising edge.
- Reset_n_i  input  1  asynchronous, active-low reset.
- Enable_i  input  1  count enable; 0 = hold.
- Up_i  input  1  direction: 1 = increment, 0 = decrement.
- Load_i  input  1  synchronous parallel load request.
- LoadData_i  input  Width  value to load.
- Data_o  output  Width  current count (register output).
- AtMax_o  output  1  high while Data_o == Max.
- AtMin_o  output  1  high while Data_o == Min.
- Wrap_o  output  1  one-cycle pulse, valid only when Wrap = 1.

Behaviour:
- Reset (asynchronous assert, released synchronously by the environment):
  - Data_o = Init, Wrap_o = 0.
  - AtMax_o = (Init == Max), AtMin_o = (Init == Min).
- Parameter checks: elaboration fails if Min > Init, Init > Max, Max > 2**Width-1 or Width < 2.
- Per-edge priority: Load_i, then Enable_i, then hold.
- Load (Load_i = 1, regardless of Enable_i / Up_i):
  - Data_o takes LoadData_i clamped to [Min, Max]: below Min gives Min, above Max gives Max.
  - Wrap_o = 0.
- Count up (Enable_i = 1, Up_i = 1):
  - Data_o < Max: Data_o + 1.
  - Data_o == Max, Wrap = 0: hold at Max.
  - Data_o == Max, Wrap = 1: Data_o = Min, Wrap_o = 1.
- Count down (Enable_i = 1, Up_i = 0):
  - Data_o > Min: Data_o - 1.
  - Data_o == Min, Wrap = 0: hold at Min.
  - Data_o == Min, Wrap = 1: Data_o = Max, Wrap_o = 1.
- Hold (Enable_i = 0, Load_i = 0): Data_o unchanged, Wrap_o = 0.
- Latency: one cycle from inputs sampled at edge N to Data_o updated after edge N.
- Wrap_o: registered, high in exactly the cycle in which Data_o first shows the wrapped value; otherwise 0.
- Flags AtMax_o / AtMin_o: decoded from the Data_o register, no extra latency. Both are high when Min == Max.
- Arithmetic: compare against the bound before increment/decrement, so no Width-bit overflow or underflow occurs even when Max = 2**Width-1 or Min = 0.
- Invariant (formal property): Min <= Data_o <= Max in every cycle after reset.
- Single-step property: if Enable_i = 1, Up_i = 1, Load_i = 0 and Data_o < Max, then the next Data_o == previous Data_o + 1. The symmetric property holds for down-counting.
- Reset mid-operation: immediate return to reset values; any in-flight load or wrap is discarded.
- Direction change while enabled takes effect on the same edge; no pipeline state.

Optional Feature:
- Macro: COUNTER_EXT_SYNC_CLEAR_EN.
- When defined:
  - Adds input port Clear_i (1 bit).
  - Clear_i = 1 on an edge sets Data_o = Init and Wrap_o = 0.
  - Clear_i has top priority, above Load_i and Enable_i.
- When undefined:
  - No Clear_i port.
  - Priority is Load_i, then Enable_i, then hold, as above.

Test Plan:
- Reset then Enable_i = 1, Up_i = 1 for 60 cycles (Init 8, Max 64, Wrap 0) -> Data_o steps 8..64, holds at 64, AtMax_o = 1, Wrap_o never asserts.
- Wrap = 1, count up from 63 -> Data_o 64 then 8; Wrap_o = 1 only in the cycle Data_o == 8; AtMin_o = 1.
- Wrap = 1, Up_i = 0 from 9 -> Data_o 8 then 64; Wrap_o pulses once.
- Load_i with LoadData_i = 3, then 100, then 20 -> Data_o 8, 64, 20; Load_i beats a simultaneous Enable_i.
- Reset_n_i asserted mid-count at Data_o = 37, asynchronously between edges -> Data_o = 8 immediately; flags and Wrap_o take their reset values.
- Width 4, Min 0, Max 15, Wrap 1 -> 15 up wraps to 0 and 0 down wraps to 15, with no X and no overflow.
- With COUNTER_EXT_SYNC_CLEAR_EN, Clear_i together with Load_i (LoadData_i = 30) at Data_o = 50 -> Data_o = 8.
